// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM brightness engine that gates a WIDTH-bit LED pattern.
// Modes: off, static level, breathing triangle fade and blink.
module led_pwm_fader #(
    parameter int WIDTH       = 16,
    parameter int CNT_W       = 6,
    parameter int PWM_PERIOD  = 31,
    parameter int TICK_DIV    = 5000000,
    parameter int BLINK_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] level,
    input  logic             hold,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] led,
    output logic [CNT_W-1:0] duty,
    output logic             period_start
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [CNT_W-1:0] P = CNT_W'(PWM_PERIOD);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PWM_PERIOD - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        OFF     = 2'b00,
        STATIC  = 2'b01,
        BREATHE = 2'b10,
        BLINK   = 2'b11
    } mode_t;

    logic [TW-1:0]    tick_cnt, tick_cnt_next;
    logic [CNT_W-1:0] pwm_cnt, pwm_cnt_next;
    mode_t            mode_q, mode_next;
    logic [CNT_W-1:0] fade, fade_next;
    logic             dir, dir_next;
    logic [BW-1:0]    blink_cnt, blink_cnt_next;
    logic             blink_on, blink_on_next;
    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] level_clamp;
    logic [CNT_W-1:0] duty_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt     <= '0;
            pwm_cnt      <= '0;
            mode_q       <= OFF;
            fade         <= '0;
            dir          <= 1'b0;
            blink_cnt    <= '0;
            blink_on     <= 1'b1;
            led          <= '0;
            duty         <= '0;
            period_start <= 1'b0;
        end else begin
            tick_cnt     <= tick_cnt_next;
            pwm_cnt      <= pwm_cnt_next;
            mode_q       <= mode_next;
            fade         <= fade_next;
            dir          <= dir_next;
            blink_cnt    <= blink_cnt_next;
            blink_on     <= blink_on_next;
            led          <= (pwm_cnt < duty_eff) ? pattern : '0;
            duty         <= duty_eff;
            period_start <= (pwm_cnt_next == '0);
        end
    end

    always_comb begin
        tick           = (tick_cnt == TICK_LAST);
        wrap           = (pwm_cnt == P_LAST);
        tick_cnt_next  = tick ? '0 : tick_cnt + TW'(1);
        pwm_cnt_next   = wrap ? '0 : pwm_cnt + CNT_W'(1);
        mode_next      = wrap ? mode_t'(mode) : mode_q;
        fade_next      = fade;
        dir_next       = dir;
        blink_cnt_next = blink_cnt;
        blink_on_next  = blink_on;

        // Entering a mode resets its state and swallows a coincident tick.
        if (mode_next != mode_q) begin
            if (mode_next == BREATHE) begin
                fade_next = '0;
                dir_next  = 1'b0;
            end else if (mode_next == BLINK) begin
                blink_cnt_next = '0;
                blink_on_next  = 1'b1;
            end
        end else if (tick && !hold) begin
            if (mode_q == BREATHE) begin
                if (!dir) begin
                    fade_next = fade + CNT_W'(1);
                    if (fade_next == P) dir_next = 1'b1;
                end else begin
                    fade_next = fade - CNT_W'(1);
                    if (fade_next == '0) dir_next = 1'b0;
                end
            end else if (mode_q == BLINK) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt_next = '0;
                    blink_on_next  = !blink_on;
                end else begin
                    blink_cnt_next = blink_cnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        level_clamp = (level > P) ? P : level;
        duty_eff    = '0;
        unique case (mode_q)
            OFF:     duty_eff = '0;
            STATIC:  duty_eff = level_clamp;
            BREATHE: duty_eff = fade;
            BLINK:   duty_eff = blink_on ? P : '0;
        endcase
    end
endmodule
